chained_stage_pipe: RTL and testbench

Parametrised, elastic successor to the fixed two-instance combine chain: a chain of `DEPTH` registered combine stages, each `WIDTH` bits wide, applying a selectable operation between the travelling data word and a per-beat auxiliary operand. Beats enter and leave through valid/ready handshakes with full throughput and per-stage backpressure. A beat counter reports delivered results. The block sits between a bus source and a bus sink wherever the design previously hard-wired two combine instances back to back.

---
 rtl/chained_stage_pipe.sv | 125 ++++++++++++
 tb/tb_chained_stage_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chained_stage_pipe.sv
// chained_stage_pipe: elastic chain of DEPTH registered combine stages.
// Each stage applies op(data, aux) to the travelling word and forwards aux
// with the beat. Stages hold while their downstream neighbour is stalled, so
// bubbles collapse and full throughput is kept while the sink is ready.
module chained_stage_pipe #(
    parameter int unsigned WIDTH = 32'd2,
    parameter int unsigned DEPTH = 32'd2,
    parameter int unsigned MODE  = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_aux,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      beat_count
);

    // Reject configurations the chain cannot build.
    if (MODE > 32'd3) begin : g_bad_mode
        $error("chained_stage_pipe: MODE must be 0..3");
    end
    if (WIDTH < 32'd1) begin : g_bad_width
        $error("chained_stage_pipe: WIDTH must be at least 1");
    end
    if (DEPTH < 32'd1) begin : g_bad_depth
        $error("chained_stage_pipe: DEPTH must be at least 1");
    end

    // Stage operation selected at elaboration time.
    function automatic logic [WIDTH-1:0] f_op(input logic [WIDTH-1:0] d,
                                              input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] res;
        case (MODE)
            32'd0:   res = d ^ a;
            32'd1:   res = d & a;
            32'd2:   res = d | a;
            32'd3:   res = d + a;
            default: res = d ^ a;
        endcase
        return res;
    endfunction

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [WIDTH-1:0] r_a [DEPTH];
    logic [15:0]      r_cnt;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic [WIDTH-1:0] w_src_a [DEPTH];
    logic             w_out_xfer;

    // Stage k is ready when it or any stage after it is empty, or the sink is
    // ready; written in closed form so no signal depends on itself.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_rdy[k] = out_ready;
            for (int j = k; j < int'(DEPTH); j++) begin
                if (!r_v[j]) begin
                    w_rdy[k] = 1'b1;
                end else begin
                    w_rdy[k] = w_rdy[k];
                end
            end
        end
    end

    // Upstream source of each stage: the input port for stage 0, the previous
    // stage otherwise.
    always_comb begin
        w_src_v[0] = in_valid;
        w_src_d[0] = in_data;
        w_src_a[0] = in_aux;
        for (int k = 1; k < int'(DEPTH); k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_d[k] = r_d[k-1];
            w_src_a[k] = r_a[k-1];
        end
    end

    assign w_out_xfer = r_v[DEPTH-1] & out_ready;

    // Stage registers: advance when ready; payload only loads on a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_d[k] <= '0;
                r_a[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_d[k] <= f_op(w_src_d[k], w_src_a[k]);
                        r_a[k] <= w_src_a[k];
                    end
                end
            end
        end
    end

    // Delivered-result counter, wraps modulo 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 16'd0;
        end else if (w_out_xfer) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign in_ready   = w_rdy[0];
    assign out_valid  = r_v[DEPTH-1];
    assign out_data   = r_d[DEPTH-1];
    assign beat_count = r_cnt;

endmodule

// File: tb/tb_chained_stage_pipe.sv
// Directed bench for chained_stage_pipe using four configurations:
// A: ADD W2 D2, B: XOR W2 D4, C: ADD W4 D3, D: AND W2 D2.
module tb_chained_stage_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    logic       a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0;
    logic [1:0] a_id = 2'd0, a_ia = 2'd0, a_od;
    logic [15:0] a_cnt;
    logic       b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0;
    logic [1:0] b_id = 2'd0, b_ia = 2'd0, b_od;
    logic [15:0] b_cnt;
    logic       c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0;
    logic [3:0] c_id = 4'd0, c_ia = 4'd0, c_od;
    logic [15:0] c_cnt;
    logic       d_iv = 1'b0, d_ir, d_ov, d_or = 1'b0;
    logic [1:0] d_id = 2'd0, d_ia = 2'd0, d_od;
    logic [15:0] d_cnt;

    chained_stage_pipe #(.WIDTH(2), .DEPTH(2), .MODE(3)) u_a (
        .clk(clk), .reset(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .in_aux(a_ia), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .beat_count(a_cnt));
    chained_stage_pipe #(.WIDTH(2), .DEPTH(4), .MODE(0)) u_b (
        .clk(clk), .reset(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .in_aux(b_ia), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .beat_count(b_cnt));
    chained_stage_pipe #(.WIDTH(4), .DEPTH(3), .MODE(3)) u_c (
        .clk(clk), .reset(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .in_aux(c_ia), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .beat_count(c_cnt));
    chained_stage_pipe #(.WIDTH(2), .DEPTH(2), .MODE(1)) u_d (
        .clk(clk), .reset(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
        .in_aux(d_ia), .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .beat_count(d_cnt));

    // Advance to 1 time unit after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", a_ov); end
        n_tests++;
        if (a_od !== 2'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", a_od); end
        n_tests++;
        if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
        n_tests++;
        if (a_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", a_ir); end
        n_tests++;
        if (c_ir !== 1'b1 || c_ov !== 1'b0) begin
            n_fail++; $display("FAIL reset_c_state: in_ready %0b out_valid %0b want 1 0", c_ir, c_ov);
        end
    endtask

    task automatic test_stream;
        a_or = 1'b1; a_iv = 1'b1; a_id = 2'd1; a_ia = 2'd1;
        step();
        n_tests++;
        if (a_ov !== 1'b0) begin n_fail++; $display("FAIL stream_latency: out_valid %0b after first edge, want 0", a_ov); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (a_ov !== 1'b1 || a_od !== 2'd3) begin
                n_fail++; $display("FAIL stream_beat%0d: valid %0b data %0d want 1 3", i, a_ov, a_od);
            end
            if (i == 2) a_iv = 1'b0;
        end
        step();
        n_tests++;
        if (a_ov !== 1'b0 || a_cnt !== 16'd4) begin
            n_fail++; $display("FAIL stream_count: valid %0b count %0d want 0 4", a_ov, a_cnt);
        end
    endtask

    task automatic test_xor_identity;
        b_or = 1'b1; b_ia = 2'd2;
        for (int cyc = 0; cyc < 8; cyc++) begin
            b_iv = (cyc < 4);
            b_id = 2'(cyc);
            step();
            n_tests++;
            if (cyc >= 3 && cyc <= 6) begin
                if (b_ov !== 1'b1 || b_od !== 2'(cyc - 3)) begin
                    n_fail++; $display("FAIL xor_out_c%0d: valid %0b data %0d want 1 %0d", cyc, b_ov, b_od, cyc - 3);
                end
            end else begin
                if (b_ov !== 1'b0) begin
                    n_fail++; $display("FAIL xor_idle_c%0d: valid %0b want 0", cyc, b_ov);
                end
            end
        end
        b_iv = 1'b0;
        n_tests++;
        if (b_cnt !== 16'd4) begin n_fail++; $display("FAIL xor_count: got %0d want 4", b_cnt); end
    endtask

    task automatic test_backpressure;
        int s = 0;
        int r = 0;
        int cyc = 0;
        c_or = 1'b0; c_ia = 4'd1;
        for (int i = 0; i < 3; i++) begin
            c_iv = 1'b1; c_id = 4'(s + 1);
            #1;
            n_tests++;
            if (c_ir !== 1'b1) begin n_fail++; $display("FAIL bp_fill%0d: in_ready %0b want 1", i, c_ir); end
            step();
            s++;
        end
        c_id = 4'(s + 1);
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++;
            if (c_ir !== 1'b0 || c_ov !== 1'b1 || c_od !== 4'd4) begin
                n_fail++;
                $display("FAIL bp_stall%0d: in_ready %0b valid %0b data %0d want 0 1 4", i, c_ir, c_ov, c_od);
            end
            step();
        end
        c_or = 1'b1;
        while (r < 5 && cyc < 20) begin
            c_iv = (s < 5);
            c_id = 4'(s + 1);
            #1;
            if (c_ov) begin
                n_tests++;
                if (c_od !== 4'(r + 4)) begin
                    n_fail++; $display("FAIL bp_order%0d: got %0d want %0d", r, c_od, r + 4);
                end
                r++;
            end
            if (c_iv && c_ir) s++;
            step();
            cyc++;
        end
        c_iv = 1'b0;
        n_tests++;
        if (r != 5) begin n_fail++; $display("FAIL bp_timeout: got %0d results want 5", r); end
        n_tests++;
        if (c_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", c_cnt); end
    endtask

    task automatic test_bubbles;
        int seen = 0;
        d_or = 1'b1; d_id = 2'd3; d_ia = 2'd1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            d_iv = (cyc == 0 || cyc == 2);
            #1;
            if (d_ov) begin
                seen++;
                n_tests++;
                if (d_od !== 2'd1) begin n_fail++; $display("FAIL bubble_data: got %0d want 1", d_od); end
            end
            step();
        end
        d_iv = 1'b0;
        n_tests++;
        if (seen != 2) begin n_fail++; $display("FAIL bubble_beats: got %0d want 2", seen); end
        n_tests++;
        if (d_cnt !== 16'd2) begin n_fail++; $display("FAIL bubble_count: got %0d want 2", d_cnt); end
    endtask

    task automatic test_reset_mid;
        a_or = 1'b0; a_iv = 1'b1; a_id = 2'd2; a_ia = 2'd1;
        step();
        step();
        n_tests++;
        if (a_ov !== 1'b1) begin n_fail++; $display("FAIL rmid_inflight: valid %0b want 1", a_ov); end
        rst = 1'b1;
        a_or = 1'b1;
        step();
        rst = 1'b0; a_iv = 1'b0; a_or = 1'b0;
        #1;
        n_tests++;
        if (a_ov !== 1'b0 || a_cnt !== 16'd0 || a_ir !== 1'b1 || a_od !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_state: valid %0b count %0d in_ready %0b data %0d want 0 0 1 0", a_ov, a_cnt, a_ir, a_od);
        end
        a_or = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost%0d: valid %0b want 0", i, a_ov); end
        end
    endtask

    task automatic test_counter_wrap;
        int t = 0;
        int cyc = 0;
        a_or = 1'b1; a_iv = 1'b1; a_id = 2'd0; a_ia = 2'd1;
        while (t < 65537 && cyc < 70000) begin
            if (a_ov) t++;
            step();
            cyc++;
            if (t == 65535 && a_ov) begin
                n_tests++;
                if (a_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %0d want 65535", a_cnt); end
            end
        end
        a_iv = 1'b0; a_or = 1'b0;
        #1;
        n_tests++;
        if (t != 65537) begin n_fail++; $display("FAIL wrap_timeout: got %0d transfers want 65537", t); end
        n_tests++;
        if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL wrap_count: got %0d want 1", a_cnt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_xor_identity();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
